// File: rtl/pixel_sink.sv
// pixel_sink: receives one frame of pixels from an upstream design output.
// It counts accepted pixels, tracks the column and row of the next expected
// pixel, keeps a running checksum, and raises sticky error flags when a pixel
// arrives outside a frame, when a frame stalls, or when a frame has zero size.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           arm reception of one frame (honoured only in IDLE)
//   size_x, size_y  frame dimensions, sampled on an honoured start
//   pixel_in        pixel data
//   pixel_valid     pixel_in valid this cycle (no backpressure)
//   busy            high while receiving a frame
//   frame_done      one-cycle pulse after the last pixel of a frame
//   pixel_count     pixels accepted in the current or last frame
//   col, row        position of the next expected pixel
//   checksum        sum mod 2^32 of zero-extended accepted pixels
//   stray_err       sticky: pixel seen outside RECEIVING
//   timeout_err     sticky: frame abandoned after TIMEOUT idle cycles
//   size_err        sticky: start honoured with a zero dimension
module pixel_sink #(
    parameter int PIXEL_W = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [11:0]        size_x,
    input  logic [11:0]        size_y,
    input  logic [PIXEL_W-1:0] pixel_in,
    input  logic               pixel_valid,
    output logic               busy,
    output logic               frame_done,
    output logic [23:0]        pixel_count,
    output logic [11:0]        col,
    output logic [11:0]        row,
    output logic [31:0]        checksum,
    output logic               stray_err,
    output logic               timeout_err,
    output logic               size_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECEIVING = 2'd1,
        DONE      = 2'd2
    } state_t;

    // Wide enough to hold TIMEOUT itself, so TIMEOUT = 1 still works.
    localparam int IW = $clog2(TIMEOUT + 1);

    state_t        state, state_next;
    logic [11:0]   size_x_r;
    logic [23:0]   total;
    logic [IW-1:0] idle_cnt;

    logic do_start;
    logic zero_size;
    logic accept;
    logic last_pix;
    logic timeout_hit;
    logic stray;

    function automatic logic [31:0] csum_add(input logic [31:0] acc,
                                             input logic [PIXEL_W-1:0] pix);
        return acc + 32'(pix);
    endfunction

    // Next-state and per-cycle event decode.
    always_comb begin
        state_next  = state;
        do_start    = 1'b0;
        zero_size   = 1'b0;
        accept      = 1'b0;
        last_pix    = 1'b0;
        timeout_hit = 1'b0;
        stray       = 1'b0;
        case (state)
            IDLE: begin
                stray = pixel_valid;
                if (start) begin
                    do_start = 1'b1;
                    if (size_x == 12'd0 || size_y == 12'd0) begin
                        zero_size  = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = RECEIVING;
                    end
                end
            end
            RECEIVING: begin
                if (pixel_valid) begin
                    accept = 1'b1;
                    if (pixel_count + 24'd1 == total) begin
                        last_pix   = 1'b1;
                        state_next = DONE;
                    end
                end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
                    // This idle cycle is the TIMEOUT-th one.
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            DONE: begin
                stray      = pixel_valid;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            size_x_r    <= '0;
            total       <= '0;
            idle_cnt    <= '0;
            pixel_count <= '0;
            col         <= '0;
            row         <= '0;
            checksum    <= '0;
            stray_err   <= 1'b0;
            timeout_err <= 1'b0;
            size_err    <= 1'b0;
        end else begin
            state <= state_next;
            if (do_start) begin
                size_x_r    <= size_x;
                total       <= 24'(size_x) * 24'(size_y);
                idle_cnt    <= '0;
                pixel_count <= '0;
                col         <= '0;
                row         <= '0;
                checksum    <= '0;
                // A pixel in the start cycle is itself stray, so it survives the clear.
                stray_err   <= stray;
                timeout_err <= 1'b0;
                size_err    <= zero_size;
            end else begin
                if (stray) begin
                    stray_err <= 1'b1;
                end
                if (timeout_hit) begin
                    timeout_err <= 1'b1;
                end
                if (accept) begin
                    pixel_count <= pixel_count + 24'd1;
                    checksum    <= csum_add(checksum, pixel_in);
                    idle_cnt    <= '0;
                    if (last_pix) begin
                        // Frame complete: position returns to origin instead of row size_y.
                        col <= '0;
                        row <= '0;
                    end else if (col == size_x_r - 12'd1) begin
                        col <= '0;
                        row <= row + 12'd1;
                    end else begin
                        col <= col + 12'd1;
                    end
                end else if (state == RECEIVING) begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
            end
        end
    end

    assign busy       = (state == RECEIVING);
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_pixel_sink.sv
module tb_pixel_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] size_x;
    logic [11:0] size_y;
    logic [7:0]  pixel_in;
    logic        pixel_valid;
    logic        busy;
    logic        frame_done;
    logic [23:0] pixel_count;
    logic [11:0] col;
    logic [11:0] row;
    logic [31:0] checksum;
    logic        stray_err;
    logic        timeout_err;
    logic        size_err;

    int vectors    = 0;
    int miscompares = 0;

    pixel_sink #(.PIXEL_W(8), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .size_x     (size_x),
        .size_y     (size_y),
        .pixel_in   (pixel_in),
        .pixel_valid(pixel_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .pixel_count(pixel_count),
        .col        (col),
        .row        (row),
        .checksum   (checksum),
        .stray_err  (stray_err),
        .timeout_err(timeout_err),
        .size_err   (size_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p);
        pixel_valid = 1'b1;
        pixel_in    = p;
        step();
        pixel_valid = 1'b0;
        pixel_in    = 8'h00;
    endtask

    task automatic begin_frame(input logic [11:0] sx, input logic [11:0] sy);
        size_x = sx;
        size_y = sy;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        vectors++;
        if ({busy, frame_done, stray_err, timeout_err, size_err} !== 5'b0) begin
            $display("FAIL reset_flags got %b exp 00000", {busy, frame_done, stray_err, timeout_err, size_err});
            miscompares++;
        end
        vectors++;
        if (pixel_count !== 24'd0 || checksum !== 32'd0 || col !== 12'd0 || row !== 12'd0) begin
            $display("FAIL reset_data got cnt=%0d sum=%0d col=%0d row=%0d exp all 0", pixel_count, checksum, col, row);
            miscompares++;
        end
    endtask

    task automatic test_basic();
        begin_frame(12'd2, 12'd2);
        vectors++;
        if (busy !== 1'b1) begin
            $display("FAIL basic_busy got %b exp 1", busy);
            miscompares++;
        end
        for (int i = 1; i <= 4; i++) begin
            send(8'(i));
            vectors++;
            if (pixel_count !== 24'(i) || frame_done !== (i == 4)) begin
                $display("FAIL basic_pix%0d got cnt=%0d done=%b exp cnt=%0d done=%b", i, pixel_count, frame_done, i, (i == 4));
                miscompares++;
            end
        end
        vectors++;
        if (checksum !== 32'd10 || busy !== 1'b0 || col !== 12'd0 || row !== 12'd0) begin
            $display("FAIL basic_end got sum=%0d busy=%b col=%0d row=%0d exp 10 0 0 0", checksum, busy, col, row);
            miscompares++;
        end
        step();
        vectors++;
        if (frame_done !== 1'b0 || pixel_count !== 24'd4 || checksum !== 32'd10) begin
            $display("FAIL basic_hold got done=%b cnt=%0d sum=%0d exp 0 4 10", frame_done, pixel_count, checksum);
            miscompares++;
        end
        vectors++;
        if ({stray_err, timeout_err, size_err} !== 3'b000) begin
            $display("FAIL basic_errs got %b exp 000", {stray_err, timeout_err, size_err});
            miscompares++;
        end
    endtask

    task automatic test_gapped();
        int done_cnt = 0;
        begin_frame(12'd3, 12'd2);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (col !== 12'(i % 3) || row !== 12'(i / 3)) begin
                $display("FAIL gap_pos%0d got (%0d,%0d) exp (%0d,%0d)", i, col, row, i % 3, i / 3);
                miscompares++;
            end
            send(8'(10 + i));
            if (frame_done === 1'b1) done_cnt++;
            if (i == 5) begin
                vectors++;
                if (col !== 12'd0 || row !== 12'd0) begin
                    $display("FAIL gap_endpos got (%0d,%0d) exp (0,0)", col, row);
                    miscompares++;
                end
            end
            step();
            if (frame_done === 1'b1) done_cnt++;
        end
        vectors++;
        if (done_cnt !== 1 || checksum !== 32'd75 || pixel_count !== 24'd6) begin
            $display("FAIL gap_end got done_pulses=%0d sum=%0d cnt=%0d exp 1 75 6", done_cnt, checksum, pixel_count);
            miscompares++;
        end
    endtask

    task automatic test_stray();
        size_x      = 12'd2;
        size_y      = 12'd1;
        start       = 1'b1;
        pixel_valid = 1'b1;
        pixel_in    = 8'd100;
        step();
        start       = 1'b0;
        pixel_valid = 1'b0;
        vectors++;
        if (stray_err !== 1'b1 || busy !== 1'b1 || checksum !== 32'd0 || pixel_count !== 24'd0) begin
            $display("FAIL stray_start got err=%b busy=%b sum=%0d cnt=%0d exp 1 1 0 0", stray_err, busy, checksum, pixel_count);
            miscompares++;
        end
        send(8'd5);
        send(8'd6);
        vectors++;
        if (frame_done !== 1'b1 || checksum !== 32'd11) begin
            $display("FAIL stray_frame got done=%b sum=%0d exp 1 11", frame_done, checksum);
            miscompares++;
        end
        send(8'd50);
        send(8'd51);
        vectors++;
        if (stray_err !== 1'b1 || pixel_count !== 24'd2 || checksum !== 32'd11 || frame_done !== 1'b0) begin
            $display("FAIL stray_after got err=%b cnt=%0d sum=%0d done=%b exp 1 2 11 0", stray_err, pixel_count, checksum, frame_done);
            miscompares++;
        end
        // Clean frame clears the flag; a pixel during DONE alone must set it.
        begin_frame(12'd1, 12'd1);
        vectors++;
        if (stray_err !== 1'b0) begin
            $display("FAIL stray_clear got %b exp 0", stray_err);
            miscompares++;
        end
        send(8'd9);
        send(8'd77);
        vectors++;
        if (stray_err !== 1'b1 || pixel_count !== 24'd1 || checksum !== 32'd9) begin
            $display("FAIL stray_done got err=%b cnt=%0d sum=%0d exp 1 1 9", stray_err, pixel_count, checksum);
            miscompares++;
        end
    endtask

    task automatic test_timeout();
        begin_frame(12'd4, 12'd4);
        send(8'd1);
        send(8'd2);
        send(8'd3);
        for (int i = 1; i <= 8; i++) begin
            step();
            vectors++;
            if (timeout_err !== (i == 8) || busy !== (i != 8) || frame_done !== 1'b0) begin
                $display("FAIL timeout_idle%0d got err=%b busy=%b done=%b exp %b %b 0", i, timeout_err, busy, frame_done, (i == 8), (i != 8));
                miscompares++;
            end
        end
        vectors++;
        if (pixel_count !== 24'd3 || checksum !== 32'd6) begin
            $display("FAIL timeout_count got cnt=%0d sum=%0d exp 3 6", pixel_count, checksum);
            miscompares++;
        end
        step();
        vectors++;
        if (frame_done !== 1'b0 || timeout_err !== 1'b1) begin
            $display("FAIL timeout_after got done=%b err=%b exp 0 1", frame_done, timeout_err);
            miscompares++;
        end
    endtask

    task automatic test_zero_size();
        begin_frame(12'd0, 12'd5);
        vectors++;
        if (size_err !== 1'b1 || frame_done !== 1'b1 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            $display("FAIL zero_start got serr=%b done=%b busy=%b terr=%b exp 1 1 0 0", size_err, frame_done, busy, timeout_err);
            miscompares++;
        end
        step();
        vectors++;
        if (frame_done !== 1'b0 || size_err !== 1'b1) begin
            $display("FAIL zero_after got done=%b serr=%b exp 0 1", frame_done, size_err);
            miscompares++;
        end
        begin_frame(12'd1, 12'd1);
        vectors++;
        if (size_err !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL zero_restart got serr=%b busy=%b exp 0 1", size_err, busy);
            miscompares++;
        end
        send(8'd7);
        vectors++;
        if (frame_done !== 1'b1 || pixel_count !== 24'd1 || checksum !== 32'd7) begin
            $display("FAIL zero_frame got done=%b cnt=%0d sum=%0d exp 1 1 7", frame_done, pixel_count, checksum);
            miscompares++;
        end
        step();
    endtask

    task automatic test_reset_mid();
        begin_frame(12'd4, 12'd4);
        for (int i = 1; i <= 5; i++) send(8'(i));
        rst         = 1'b1;
        start       = 1'b1;
        pixel_valid = 1'b1;
        pixel_in    = 8'd33;
        step();
        rst         = 1'b0;
        start       = 1'b0;
        pixel_valid = 1'b0;
        vectors++;
        if ({busy, frame_done, stray_err, timeout_err, size_err} !== 5'b0 ||
            pixel_count !== 24'd0 || checksum !== 32'd0 || col !== 12'd0 || row !== 12'd0) begin
            $display("FAIL rst_mid got busy=%b done=%b cnt=%0d sum=%0d col=%0d row=%0d exp all 0",
                     busy, frame_done, pixel_count, checksum, col, row);
            miscompares++;
        end
        begin_frame(12'd4, 12'd4);
        for (int i = 1; i <= 16; i++) send(8'(i));
        vectors++;
        if (frame_done !== 1'b1 || pixel_count !== 24'd16 || checksum !== 32'd136) begin
            $display("FAIL rst_newframe got done=%b cnt=%0d sum=%0d exp 1 16 136", frame_done, pixel_count, checksum);
            miscompares++;
        end
        step();
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        size_x      = 12'd0;
        size_y      = 12'd0;
        pixel_in    = 8'd0;
        pixel_valid = 1'b0;
        test_reset();
        test_basic();
        test_gapped();
        test_stray();
        test_timeout();
        test_zero_size();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
